decy_master: RTL

Pixel decryptor for the batch image pipeline: takes a stream of encrypted 24-bit RGB pixels and recovers the plaintext pixels, one pixel per clock at full throughput. Each pixel is decrypted with a per-pixel 24-bit LFSR keystream (per-channel rotate-right, then XOR).
- Sits downstream of the encrypted-image source and is the inverse of the encryption master.
- Has a 2-stage elastic pipeline with valid/ready handshaking and frame-length control.

---
 rtl/decy_master.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/decy_master.sv
// ---------------------------------------------------------------------------
// decy_master
// Pixel decryptor for the batch image pipeline. Recovers plaintext 24-bit RGB
// pixels from a cipher stream at one pixel per clock. Each pixel p uses the
// keystream word ks_p, which is the LFSR value at the moment p is accepted.
// Each channel is rotated right by a keystream-selected amount and then XORed
// with a keystream byte.
//
// Pipeline: S1 registers the rotated channels and ks_p. S2 applies the XOR
// and drives o/out_valid. Both stages advance together when
// out_ready || !out_valid.
//
// Ports:
//   clk         clock, rising edge
//   rst         synchronous active-high reset
//   seed_ld     load seed_in as the frame seed (IDLE only; zero -> SEED)
//   seed_in     seed value
//   start       begin a frame (IDLE only)
//   in_valid    cipher pixel present on i
//   i           cipher pixel {R,G,B}
//   in_ready    pixel accepted when in_valid && in_ready
//   o           decrypted pixel {R,G,B}
//   out_valid   o is valid
//   out_ready   sink accepts o
//   frame_done  one-cycle pulse when a frame has fully drained
//   frame_cnt   (DECY_FRAME_CNT_EN only) count of completed frames, wraps
//
// Optional feature macro: DECY_FRAME_CNT_EN
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; seed loads honoured; no input accepted
// RUN   | accepting pixels until NPIX have been taken
// DRAIN | no input; waiting for S1/S2 to empty, then frame_done
// ---------------------------------------------------------------------------
module decy_master #(
   parameter logic [23:0] SEED = 24'hA5C3E1,
   parameter int unsigned NPIX = 1048576
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        seed_ld,
   input  logic [23:0] seed_in,
   input  logic        start,
   input  logic        in_valid,
   input  logic [23:0] i,
   output logic        in_ready,
   output logic [23:0] o,
   output logic        out_valid,
   input  logic        out_ready,
   output logic        frame_done
`ifdef DECY_FRAME_CNT_EN
  ,output logic [15:0] frame_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   // Index of the final pixel of a frame; NPIX itself may not fit in 20 bits.
   localparam logic [19:0] LAST_IDX = 20'(NPIX - 1);

   state_t      r_state;
   state_t      w_state_nxt;
   logic [23:0] r_lfsr;
   logic [23:0] r_seed_reg;
   logic [19:0] r_cnt;
   logic        r_s1_valid;
   logic [23:0] r_s1_rot;
   logic [23:0] r_s1_ks;

   logic        w_en;
   logic        w_accept;
   logic        w_last;
   logic        w_empty;
   logic [23:0] w_seed_sel;
   logic [23:0] w_lfsr_step;
   logic [23:0] w_rot;

   function automatic logic [7:0] f_rotr(input logic [7:0] x, input logic [2:0] n);
      return 8'({x, x} >> n);
   endfunction

   assign w_en        = out_ready || !out_valid;
   assign w_accept    = in_valid && (r_state == RUN) && w_en;
   assign w_last      = (r_cnt == LAST_IDX);
   assign w_empty     = !r_s1_valid && !out_valid;
   assign w_seed_sel  = (seed_in == 24'h000000) ? SEED : seed_in;
   assign w_lfsr_step = {r_lfsr[22:0], r_lfsr[23] ^ r_lfsr[22] ^ r_lfsr[21] ^ r_lfsr[16]};
   assign w_rot       = {f_rotr(i[23:16], r_lfsr[2:0]),
                         f_rotr(i[15:8],  r_lfsr[10:8]),
                         f_rotr(i[7:0],   r_lfsr[18:16])};

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      frame_done  = 1'b0;
      case (r_state)
         IDLE: begin
            if (start) w_state_nxt = RUN;
         end
         RUN: begin
            in_ready = w_en;
            if (w_accept && w_last) w_state_nxt = DRAIN;
         end
         DRAIN: begin
            if (w_empty) begin
               frame_done  = 1'b1;
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   // Keystream, frame seed and pixel count.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lfsr     <= SEED;
         r_seed_reg <= SEED;
         r_cnt      <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               // A seed loaded together with start is already in r_lfsr for pixel 0.
               if (seed_ld) begin
                  r_seed_reg <= w_seed_sel;
                  r_lfsr     <= w_seed_sel;
               end
               if (start) r_cnt <= '0;
            end
            RUN: begin
               if (w_accept) begin
                  r_lfsr <= w_lfsr_step;
                  // Count holds on the final pixel; it is cleared leaving DRAIN.
                  if (!w_last) r_cnt <= r_cnt + 20'd1;
               end
            end
            DRAIN: begin
               if (w_empty) begin
                  r_lfsr <= r_seed_reg;
                  r_cnt  <= '0;
               end
            end
            default: ;
         endcase
      end
   end

   // Two-stage elastic pipeline; a non-accepting cycle injects a bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s1_rot   <= '0;
         r_s1_ks    <= '0;
         out_valid  <= 1'b0;
         o          <= '0;
      end else if (w_en) begin
         r_s1_valid <= w_accept;
         if (w_accept) begin
            r_s1_rot <= w_rot;
            r_s1_ks  <= r_lfsr;
         end
         out_valid <= r_s1_valid;
         if (r_s1_valid) o <= r_s1_rot ^ r_s1_ks;
      end
   end

`ifdef DECY_FRAME_CNT_EN
   logic [15:0] r_frame_cnt;

   always_ff @(posedge clk) begin
      if (rst)             r_frame_cnt <= '0;
      else if (frame_done) r_frame_cnt <= r_frame_cnt + 16'd1;
   end

   assign frame_cnt = r_frame_cnt;
`endif

endmodule
